mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative multiply/divide sequencer for the pipelined MIPS core. It implements MULTU and DIVU by driving the shared 32-bit ALU, one add or subtract step per cycle for 32 cycles, and commits the 64-bit result to the HI/LO registers. It sits beside the EX stage; the hazard unit stalls on `busy`. The ALU stays a separate instance: this block only owns its operand and control inputs while running.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request pulse, sampled at the rising edge
- `op`  in  1  0 = multiply (MULTU), 1 = divide (DIVU)
- `src_a`  in  32  multiplicand / dividend
- `src_b`  in  32  multiplier / divisor
- `alu_a`  out  32  operand a to the ALU
- `alu_b`  out  32  operand b to the ALU
- `alu_cont`  out  3  ALU control: `3'b010` add, `3'b110` sub
- `alu_result`  in  32  ALU result, combinational, same cycle
- `busy`  out  1  high while an operation is running
- `done`  out  1  one-cycle pulse when `hi`/`lo` have just been written
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- FSM states:
  - IDLE: accepts `start`; next state RUN.
  - RUN: 32 iterations, tracked by a 5-bit counter; next state DONE after the 32nd iteration.
  - DONE: accepts `start` (next RUN); otherwise next IDLE.
- `start` is ignored in RUN. The operands and `op` are captured into working registers on acceptance.
- Multiply (unsigned shift-add):
  - Working registers: P_hi = 0, P_lo = `src_b`, M = `src_a`.
  - ALU drive: `alu_a` = P_hi, `alu_b` = M, `alu_cont` = `3'b010`.
  - carry = (`alu_result` < P_hi), unsigned compare.
  - If P_lo[0] = 1: {P_hi,P_lo} ← {carry, `alu_result`, P_lo} >> 1. Otherwise {P_hi,P_lo} ← {1'b0, P_hi, P_lo} >> 1.
  - Commit: `hi` = P_hi, `lo` = P_lo.
- Divide (unsigned restoring):
  - Working registers: R = 0, Q = `src_a`, D = `src_b`.
  - Per iteration, first form R' = {R[30:0], Q[31]}, with out-bit = R[31].
  - ALU drive: `alu_a` = R', `alu_b` = D, `alu_cont` = `3'b110`.
  - If out-bit = 1 or R' ≥ D: R ← `alu_result`, Q ← {Q[30:0], 1}. Otherwise R ← R', Q ← {Q[30:0], 0}.
  - Commit: `hi` = R (remainder), `lo` = Q (quotient).
  - Divide by zero needs no special case: the result falls out naturally as `lo` = 32'hFFFF_FFFF, `hi` = `src_a`.
- Outside RUN: `alu_a` = 0, `alu_b` = 0, `alu_cont` = `3'b010`.
- `hi`/`lo` hold their value except at commit.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0, working registers = 0.
- Reset asserted in RUN aborts the operation. `hi`/`lo` are cleared; no `done` is produced.
- Sequence for a start accepted at edge E0:
  - `busy` = 1 from after E0 through E32.
  - Iterations occur at edges E1..E32.
  - At E32: `hi`/`lo` are written and `done` = 1 for the cycle after E32; `busy` = 0 in that cycle.
  - Fixed latency: 32 cycles from the accepting edge to visible result.
- `start` in the DONE cycle: accepted. `busy` = 1 and `done` = 0 at the next edge (back-to-back operations, 33-cycle throughput).
- `busy` is registered. `alu_*` outputs are combinational from state and working registers.

## Configuration
- `MDU_DIV_EN` defined: divide path present, as described above.
- `MDU_DIV_EN` undefined:
  - Divide logic is omitted.
  - `start` with `op` = 1 is ignored: FSM stays in IDLE, `busy`/`done` stay 0, `hi`/`lo` unchanged.
  - `alu_cont` is never `3'b110`.

## Test plan
- Multiply 7 × 6: `busy` high for 32 cycles; `done` pulses; `hi` = 0, `lo` = 42.
- Multiply 32'hFFFF_FFFF × 32'hFFFF_FFFF: `hi` = 32'hFFFF_FFFE, `lo` = 32'h0000_0001. Exercises carry generation.
- Divide 100 ÷ 7: `lo` = 14, `hi` = 2. Divide 32'h8000_0001 ÷ 32'h8000_0000: `lo` = 1, `hi` = 1.
- Divide 0x1234 ÷ 0: `lo` = 32'hFFFF_FFFF, `hi` = 0x1234. Without `MDU_DIV_EN`: no `busy`, no `done`, `hi`/`lo` unchanged.
- Second `start` (3 × 3) mid-run of 5 × 5 is ignored: result `lo` = 25. `start` 4 × 4 in the DONE cycle: `lo` = 16 exactly 32 cycles later.
- `reset` at RUN iteration 10: next cycle `busy` = 0, `hi` = `lo` = 0. No `done` appears in the following 40 cycles.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULTU/DIVU sequencer for the pipelined MIPS core.
// It uses the shared external 32-bit ALU for one add or subtract step per
// cycle, runs 32 iterations, and then commits a 64-bit result to HI/LO.
// Build option: define MDU_DIV_EN to include the restoring-divide path.
// When MDU_DIV_EN is undefined, a start request with op=1 is dropped.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no operation in flight; accepts start
// S_RUN  | 32 iterations, one ALU step per cycle
// S_DONE | HI/LO just written (done pulse); accepts back-to-back start
module mdu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_cont,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] ALU_ADD = 3'b010;
`ifdef MDU_DIV_EN
    localparam logic [2:0] ALU_SUB = 3'b110;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  iter_cnt;
    logic        last_iter;
    logic        start_ok;
    logic        accept;

    // Working registers: work_hi/work_lo hold P_hi/P_lo (multiply) or
    // R/Q (divide); work_m holds the multiplicand or the divisor.
    logic [31:0] work_hi;
    logic [31:0] work_lo;
    logic [31:0] work_m;
    logic [31:0] work_hi_next;
    logic [31:0] work_lo_next;
    logic        carry;

`ifdef MDU_DIV_EN
    logic        op_div;
    logic [31:0] rem_shift;
    logic        out_bit;
    logic        div_take;

    assign start_ok  = start;
    assign rem_shift = {work_hi[30:0], work_lo[31]};
    assign out_bit   = work_hi[31];
    // out_bit set means the true 33-bit partial remainder is >= 2^32 > D.
    assign div_take  = out_bit || (rem_shift >= work_m);
`else
    assign start_ok  = start && !op;
`endif

    assign last_iter = (iter_cnt == 5'd31);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the accept strobe.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start_ok) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered status flags: busy follows the next state; done marks the commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_RUN);
            done <= (state == S_RUN) && last_iter;
        end
    end

    // ALU operand/control drive; idle values are used whenever not running.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cont = ALU_ADD;
        if (state == S_RUN) begin
`ifdef MDU_DIV_EN
            if (op_div) begin
                alu_a    = rem_shift;
                alu_b    = work_m;
                alu_cont = ALU_SUB;
            end else begin
                alu_a    = work_hi;
                alu_b    = work_m;
            end
`else
            alu_a = work_hi;
            alu_b = work_m;
`endif
        end
    end

    // Single iteration step computed from the ALU result.
    always_comb begin
        // A wrap on the add shows up as a result smaller than an operand.
        carry = (alu_result < work_hi);
        if (work_lo[0]) begin
            work_hi_next = {carry, alu_result[31:1]};
            work_lo_next = {alu_result[0], work_lo[31:1]};
        end else begin
            work_hi_next = {1'b0, work_hi[31:1]};
            work_lo_next = {work_hi[0], work_lo[31:1]};
        end
`ifdef MDU_DIV_EN
        if (op_div) begin
            if (div_take) begin
                work_hi_next = alu_result;
                work_lo_next = {work_lo[30:0], 1'b1};
            end else begin
                work_hi_next = rem_shift;
                work_lo_next = {work_lo[30:0], 1'b0};
            end
        end
`endif
    end

    // Working registers and iteration counter: load on accept, step while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_hi  <= '0;
            work_lo  <= '0;
            work_m   <= '0;
            iter_cnt <= '0;
`ifdef MDU_DIV_EN
            op_div   <= 1'b0;
`endif
        end else if (accept) begin
            work_hi  <= '0;
            iter_cnt <= '0;
`ifdef MDU_DIV_EN
            op_div   <= op;
            work_lo  <= op ? src_a : src_b;
            work_m   <= op ? src_b : src_a;
`else
            work_lo  <= src_b;
            work_m   <= src_a;
`endif
        end else if (state == S_RUN) begin
            work_hi  <= work_hi_next;
            work_lo  <= work_lo_next;
            iter_cnt <= iter_cnt + 5'd1;
        end
    end

    // HI/LO commit on the final iteration; they hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if ((state == S_RUN) && last_iter) begin
            hi <= work_hi_next;
            lo <= work_lo_next;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Testbench for mdu_seq: an ALU model, a vector table, hand-written
// sequences for the multi-cycle corners, and random operations checked
// against plain 64-bit arithmetic.
module tb_mdu_seq;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_cont;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic saw_sub = 1'b0;

    always #5 clk = ~clk;

    // External ALU: add for 010, subtract for 110.
    assign alu_result = (alu_cont == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

    always @(posedge clk) if (alu_cont == 3'b110) saw_sub <= 1'b1;

    mdu_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
        .alu_result(alu_result),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_model(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (!o) r = {32'd0, a} * {32'd0, b};
        else if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
        return r;
    endfunction

    // Issue one operation; returns cycles from accepting edge to done (-1 on timeout),
    // number of busy samples before done, and whether busy=1/done=0 right after acceptance.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output logic first_ok);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        first_ok = busy && !done;
        if (busy) busy_cnt++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                if (busy) busy_cnt = 99;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bcnt;
        logic f_ok;
        logic [63:0] exp;
        logic seen;
        logic o;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("reset_state", {busy, done, hi, lo}, {2'b00, 64'd0});
        check("reset_alu", {alu_a, alu_b, alu_cont}, {64'd0, 3'b010});

        vecs.push_back('{1'b0, 32'd7, 32'd6, 32'd0, 32'd42});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'd0, 32'h1234_5678, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'd2, 32'd1, 32'd0});
`ifdef MDU_DIV_EN
        vecs.push_back('{1'b1, 32'd100, 32'd7, 32'd2, 32'd14});
        vecs.push_back('{1'b1, 32'h8000_0001, 32'h8000_0000, 32'd1, 32'd1});
        vecs.push_back('{1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 32'd5, 32'd9, 32'd5, 32'd0});
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, f_ok);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd32);
            check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // Second start mid-run is ignored; changing operand inputs has no effect.
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_a = 32'd5; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; src_a = 32'd3; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 11; c <= 45; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        check("midrun_latency", 64'(lat), 64'd32);
        check("midrun_result", {hi, lo}, 64'd25);

        // Start in the DONE cycle: back-to-back operation.
        run_op(1'b0, 32'd4, 32'd4, lat, bcnt, f_ok);
        check("b2b_accept", {63'd0, f_ok}, 64'd1);
        check("b2b_latency", 64'(lat), 64'd32);
        check("b2b_result", {hi, lo}, 64'd16);
        @(posedge clk); #1;
        check("after_done_idle", {busy, done, alu_a, alu_b, alu_cont}, {2'b00, 64'd0, 3'b010});

        // Reset during RUN at iteration 10 aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("abort_state", {busy, hi, lo}, {1'b0, 64'd0});
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", {63'd0, seen}, 64'd0);

`ifndef MDU_DIV_EN
        // Without the divide path a divide request is dropped.
        run_op(1'b0, 32'd11, 32'd13, lat, bcnt, f_ok);
        check("pre_div_result", {hi, lo}, 64'd143);
        @(negedge clk);
        start = 1'b1; op = 1'b1; src_a = 32'h1234; src_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        repeat (36) begin
            if (busy || done) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("nodiv_ignored", {63'd0, seen}, 64'd0);
        check("nodiv_hilo_held", {hi, lo}, 64'd143);
`endif

        // Random operations against the arithmetic reference.
        for (int k = 0; k < 30; k++) begin
            o = DIV_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: a = $urandom_range(0, 15);
                2: b = $urandom_range(0, 15);
                default: b = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'hFFFF_FFFF;
            endcase
            exp = ref_model(o, a, b);
            run_op(o, a, b, lat, bcnt, f_ok);
            check($sformatf("rnd%0d_latency op=%0d", k, o), 64'(lat), 64'd32);
            check($sformatf("rnd%0d_result op=%0d a=%h b=%h", k, o, a, b), {hi, lo}, exp);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        check("alu_sub_usage", {63'd0, saw_sub}, {63'd0, DIV_EN});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
